// File: rtl/hazard5_branch_predictor_if.sv
// rtl/hazard5_branch_predictor_if.sv - decode lookup and X-stage training bundle for the branch predictor
interface hazard5_branch_predictor_if #(
  parameter int W_ADDR    = 32,
  parameter int N_ENTRIES = 4
);
  localparam int W_CNT = $clog2(N_ENTRIES) + 1;

  logic              d_vld;
  logic [W_ADDR-1:0] d_pc;
  logic              d_is_branch;
  logic              d_is_jal;
  logic              d_imm_neg;
  logic [W_ADDR-1:0] d_target;
  logic              p_taken;
  logic [W_ADDR-1:0] p_target;
  logic              bp_hit;

  logic              x_update_vld;
  logic              x_stall;
  logic [W_ADDR-1:0] x_pc;
  logic              x_taken;
  logic              flush;
  logic [W_CNT-1:0]  bp_n_valid;

  modport master (
    output d_vld, d_pc, d_is_branch, d_is_jal, d_imm_neg, d_target,
    output x_update_vld, x_stall, x_pc, x_taken, flush,
    input  p_taken, p_target, bp_hit, bp_n_valid
  );

  modport slave (
    input  d_vld, d_pc, d_is_branch, d_is_jal, d_imm_neg, d_target,
    input  x_update_vld, x_stall, x_pc, x_taken, flush,
    output p_taken, p_target, bp_hit, bp_n_valid
  );
endinterface

// File: rtl/hazard5_branch_predictor.sv
// rtl/hazard5_branch_predictor.sv - static or fully-associative 2-bit counter jump/branch predictor
module hazard5_branch_predictor #(
  parameter int W_ADDR    = 32,
  parameter int N_ENTRIES = 4,
  parameter int MODE      = 1,
  parameter int W_CNT     = $clog2(N_ENTRIES) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hazard5_branch_predictor_if.slave  bp
);
  localparam int W_IDX = $clog2(N_ENTRIES);
  localparam int W_TAG = W_ADDR - 1;

  logic pred_dir;
  logic unused_pc_lsb;

  // Instructions are at least halfword aligned, so bit 0 never takes part in a tag.
  assign unused_pc_lsb = ^{bp.d_pc[0], bp.x_pc[0]};

  assign bp.p_target = bp.d_target;
  assign bp.p_taken  = bp.d_vld & (bp.d_is_jal | (bp.d_is_branch & pred_dir));

  generate
    if (MODE == 1) begin : g_table
      logic [N_ENTRIES-1:0] valid_q, valid_d;
      logic [W_TAG-1:0]     tag_q [N_ENTRIES];
      logic [W_TAG-1:0]     tag_d [N_ENTRIES];
      logic [1:0]           cnt_q [N_ENTRIES];
      logic [1:0]           cnt_d [N_ENTRIES];
      logic [W_IDX-1:0]     rr_ptr_q, rr_ptr_d;
      logic [W_CNT-1:0]     n_valid_q, n_valid_d;

      logic             hit_d;
      logic [1:0]       hit_cnt;
      logic             x_hit;
      logic [W_IDX-1:0] x_idx;
      logic             free_found;
      logic [W_IDX-1:0] free_idx;
      logic [W_IDX-1:0] alloc_idx;
      logic             upd_en;

      always_comb begin
        hit_d   = 1'b0;
        hit_cnt = 2'b00;
        for (int i = 0; i < N_ENTRIES; i++) begin
          if (valid_q[i] && tag_q[i] == bp.d_pc[W_ADDR-1:1]) begin
            hit_d   = 1'b1;
            hit_cnt = cnt_q[i];
          end
        end
      end

      // Descending scan so the lowest-index free entry wins.
      always_comb begin
        x_hit      = 1'b0;
        x_idx      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
          if (valid_q[i] && tag_q[i] == bp.x_pc[W_ADDR-1:1]) begin
            x_hit = 1'b1;
            x_idx = W_IDX'(i);
          end
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
          if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = W_IDX'(i);
          end
        end
      end

      always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        n_valid_d = n_valid_q;
        alloc_idx = free_found ? free_idx : rr_ptr_q;
        upd_en    = bp.x_update_vld & ~bp.x_stall;
        if (bp.flush) begin
          valid_d   = '0;
          rr_ptr_d  = '0;
          n_valid_d = '0;
        end else if (upd_en) begin
          if (x_hit) begin
            if (bp.x_taken && cnt_q[x_idx] != 2'b11) begin
              cnt_d[x_idx] = cnt_q[x_idx] + 2'd1;
            end else if (!bp.x_taken && cnt_q[x_idx] != 2'b00) begin
              cnt_d[x_idx] = cnt_q[x_idx] - 2'd1;
            end
          end else begin
            valid_d[alloc_idx] = 1'b1;
            tag_d[alloc_idx]   = bp.x_pc[W_ADDR-1:1];
            cnt_d[alloc_idx]   = bp.x_taken ? 2'b10 : 2'b01;
            if (free_found) begin
              n_valid_d = n_valid_q + W_CNT'(1);
            end else begin
              rr_ptr_d = rr_ptr_q + W_IDX'(1);
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q   <= '0;
          rr_ptr_q  <= '0;
          n_valid_q <= '0;
          for (int i = 0; i < N_ENTRIES; i++) begin
            tag_q[i] <= '0;
            cnt_q[i] <= 2'b00;
          end
        end else begin
          valid_q   <= valid_d;
          tag_q     <= tag_d;
          cnt_q     <= cnt_d;
          rr_ptr_q  <= rr_ptr_d;
          n_valid_q <= n_valid_d;
        end
      end

      assign pred_dir      = hit_d ? hit_cnt[1] : bp.d_imm_neg;
      assign bp.bp_hit     = bp.d_vld & bp.d_is_branch & hit_d;
      assign bp.bp_n_valid = n_valid_q;
    end else begin : g_static
      logic unused_static;

      assign unused_static = ^{clk, rst_n, bp.x_update_vld, bp.x_stall, bp.x_pc,
                               bp.x_taken, bp.flush};
      assign pred_dir      = bp.d_imm_neg;
      assign bp.bp_hit     = 1'b0;
      assign bp.bp_n_valid = '0;
    end
  endgenerate
endmodule

// File: tb/tb_hazard5_branch_predictor.sv
// tb/tb_hazard5_branch_predictor.sv - directed bench for the table and static predictor modes
module tb_hazard5_branch_predictor;
  logic        clk;
  logic        rst_n;
  logic        d_vld, d_is_branch, d_is_jal, d_imm_neg;
  logic [31:0] d_pc, d_target;
  logic        x_update_vld, x_stall, x_taken, flush;
  logic [31:0] x_pc;

  int n_checks;
  int n_fail;

  hazard5_branch_predictor_if #(.W_ADDR(32), .N_ENTRIES(4)) bif1 ();
  hazard5_branch_predictor_if #(.W_ADDR(32), .N_ENTRIES(4)) bif0 ();

  assign bif1.d_vld = d_vld;               assign bif0.d_vld = d_vld;
  assign bif1.d_pc = d_pc;                 assign bif0.d_pc = d_pc;
  assign bif1.d_is_branch = d_is_branch;   assign bif0.d_is_branch = d_is_branch;
  assign bif1.d_is_jal = d_is_jal;         assign bif0.d_is_jal = d_is_jal;
  assign bif1.d_imm_neg = d_imm_neg;       assign bif0.d_imm_neg = d_imm_neg;
  assign bif1.d_target = d_target;         assign bif0.d_target = d_target;
  assign bif1.x_update_vld = x_update_vld; assign bif0.x_update_vld = x_update_vld;
  assign bif1.x_stall = x_stall;           assign bif0.x_stall = x_stall;
  assign bif1.x_pc = x_pc;                 assign bif0.x_pc = x_pc;
  assign bif1.x_taken = x_taken;           assign bif0.x_taken = x_taken;
  assign bif1.flush = flush;               assign bif0.flush = flush;

  hazard5_branch_predictor #(.W_ADDR(32), .N_ENTRIES(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bp(bif1.slave)
  );
  hazard5_branch_predictor #(.W_ADDR(32), .N_ENTRIES(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bp(bif0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        br;
    logic        jal;
    logic        neg;
    logic [31:0] pc;
    logic        exp_taken1;
    logic        exp_hit1;
    logic        exp_taken0;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_d(input logic vld, input logic br, input logic jal,
                         input logic neg, input logic [31:0] pc);
    d_vld       = vld;
    d_is_branch = br;
    d_is_jal    = jal;
    d_imm_neg   = neg;
    d_pc        = pc;
    d_target    = neg ? pc - 32'h80 : pc + 32'h40;
    #1;
  endtask

  task automatic chk_static(input string name);
    chk({name, "_m0_taken"}, {31'd0, bif0.p_taken},
        {31'd0, d_vld & (d_is_jal | (d_is_branch & d_imm_neg))});
    chk({name, "_m0_hit"}, {31'd0, bif0.bp_hit}, 32'd0);
    chk({name, "_m0_nvalid"}, {29'd0, bif0.bp_n_valid}, 32'd0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic neg,
                      input logic exp_hit, input logic exp_taken);
    apply_d(1'b1, 1'b1, 1'b0, neg, pc);
    chk({name, "_hit"}, {31'd0, bif1.bp_hit}, {31'd0, exp_hit});
    chk({name, "_taken"}, {31'd0, bif1.p_taken}, {31'd0, exp_taken});
    chk_static(name);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    x_pc         = pc;
    x_taken      = taken;
    x_update_vld = 1'b1;
    @(posedge clk);
    #1;
    x_update_vld = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    d_vld = 1'b0; d_is_branch = 1'b0; d_is_jal = 1'b0; d_imm_neg = 1'b0;
    d_pc = '0; d_target = '0;
    x_update_vld = 1'b0; x_stall = 1'b0; x_pc = '0; x_taken = 1'b0; flush = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h10c, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_nvalid", {29'd0, bif1.bp_n_valid}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      apply_d(vecs[i].vld, vecs[i].br, vecs[i].jal, vecs[i].neg, vecs[i].pc);
      chk($sformatf("vec%0d_taken", i), {31'd0, bif1.p_taken}, {31'd0, vecs[i].exp_taken1});
      chk($sformatf("vec%0d_hit", i), {31'd0, bif1.bp_hit}, {31'd0, vecs[i].exp_hit1});
      chk($sformatf("vec%0d_target", i), bif1.p_target, d_target);
      chk($sformatf("vec%0d_m0_taken", i), {31'd0, bif0.p_taken}, {31'd0, vecs[i].exp_taken0});
      chk($sformatf("vec%0d_m0_target", i), bif0.p_target, d_target);
    end

    // Counter training and saturation on a forward branch.
    upd(32'h100, 1'b1);
    chk("train_nvalid", {29'd0, bif1.bp_n_valid}, 32'd1);
    look("train_c2", 32'h100, 1'b0, 1'b1, 1'b1);
    upd(32'h100, 1'b0);
    look("train_c1", 32'h100, 1'b0, 1'b1, 1'b0);
    upd(32'h100, 1'b0);
    look("train_c0", 32'h100, 1'b1, 1'b1, 1'b0);
    upd(32'h100, 1'b0);
    look("sat_lo", 32'h100, 1'b1, 1'b1, 1'b0);
    upd(32'h100, 1'b1);
    look("sat_lo_up", 32'h100, 1'b0, 1'b1, 1'b0);
    upd(32'h100, 1'b1);
    look("up_c2", 32'h100, 1'b0, 1'b1, 1'b1);
    upd(32'h100, 1'b1);
    upd(32'h100, 1'b1);
    upd(32'h100, 1'b0);
    look("sat_hi_c2", 32'h100, 1'b0, 1'b1, 1'b1);
    upd(32'h100, 1'b0);
    look("sat_hi_c1", 32'h100, 1'b0, 1'b1, 1'b0);
    chk("train_nvalid_hold", {29'd0, bif1.bp_n_valid}, 32'd1);

    // Same-cycle lookup and update: no bypass.
    upd(32'h100, 1'b1);
    x_pc = 32'h100; x_taken = 1'b0; x_update_vld = 1'b1;
    look("conflict_pre", 32'h100, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 x_update_vld = 1'b0;
    look("conflict_post", 32'h100, 1'b0, 1'b1, 1'b0);

    // Flush wins over a same-cycle update of a new PC.
    flush = 1'b1;
    x_pc = 32'h200; x_taken = 1'b1; x_update_vld = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; x_update_vld = 1'b0;
    chk("flush_nvalid", {29'd0, bif1.bp_n_valid}, 32'd0);
    look("flush_old", 32'h100, 1'b0, 1'b0, 1'b0);
    look("flush_new", 32'h200, 1'b0, 1'b0, 1'b0);

    x_stall = 1'b1;
    upd(32'h300, 1'b1);
    x_stall = 1'b0;
    chk("stall_nvalid", {29'd0, bif1.bp_n_valid}, 32'd0);
    look("stall_miss", 32'h300, 1'b0, 1'b0, 1'b0);

    // Fill then round-robin replacement.
    upd(32'h10, 1'b1);
    upd(32'h20, 1'b1);
    upd(32'h30, 1'b1);
    upd(32'h40, 1'b1);
    chk("fill_nvalid", {29'd0, bif1.bp_n_valid}, 32'd4);
    look("fill_hit10", 32'h10, 1'b0, 1'b1, 1'b1);
    upd(32'h50, 1'b0);
    chk("repl_nvalid", {29'd0, bif1.bp_n_valid}, 32'd4);
    look("repl0_miss10", 32'h10, 1'b1, 1'b0, 1'b1);
    look("repl0_hit50", 32'h50, 1'b1, 1'b1, 1'b0);
    upd(32'h60, 1'b1);
    look("repl1_miss20", 32'h20, 1'b0, 1'b0, 1'b0);
    look("repl1_hit60", 32'h60, 1'b0, 1'b1, 1'b1);
    look("repl1_hit30", 32'h30, 1'b0, 1'b1, 1'b1);
    upd(32'h30, 1'b0);
    upd(32'h70, 1'b1);
    look("repl2_miss30", 32'h30, 1'b0, 1'b0, 1'b0);
    look("repl2_hit40", 32'h40, 1'b0, 1'b1, 1'b1);
    look("repl2_hit70", 32'h70, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_nvalid", {29'd0, bif1.bp_n_valid}, 32'd0);
    look("async_rst_miss", 32'h40, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("post_rst_miss", 32'h70, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
